// File: rtl/md_init_stream_feeder.sv
// Init-stage feeder: buffers back-pressured host beats in a FIFO and replays
// them as gap-free BEATS_PER_STEP bursts, tracking step count and tlast framing.
module md_init_stream_feeder #(
  parameter int DATA_WIDTH     = 512,
  parameter int BEATS_PER_STEP = 16,
  parameter int NUM_STEPS      = 4,
  parameter int FIFO_DEPTH     = 32,
  parameter int STEP_WIDTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] o_init_tdata,
  output logic                  o_init_tvalid,
  output logic [STEP_WIDTH-1:0] o_step,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_tlast
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int TOTAL = NUM_STEPS * BEATS_PER_STEP;
  localparam int ACW   = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(BEATS_PER_STEP + 1);

  localparam logic [CW-1:0]         BPS_C       = CW'(BEATS_PER_STEP);
  localparam logic [CW-1:0]         DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [ACW-1:0]        TOTAL_C     = ACW'(TOTAL);
  localparam logic [ACW-1:0]        LAST_IDX_C  = ACW'(TOTAL - 1);
  localparam logic [BW-1:0]         LAST_BEAT_C = BW'(BEATS_PER_STEP - 1);
  localparam logic [STEP_WIDTH-1:0] LAST_STEP_C = STEP_WIDTH'(NUM_STEPS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic [ACW-1:0]        acc_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [STEP_WIDTH-1:0] step;
  logic                  push, pop, last_pop, start_seq;

  always_comb begin
    s_axis_tready = !rst && (state == FILL || state == DRAIN)
                    && (count < DEPTH_C) && (acc_cnt < TOTAL_C);
    push       = s_axis_tvalid && s_axis_tready;
    pop        = (state == DRAIN);
    last_pop   = pop && (beat_cnt == LAST_BEAT_C);
    start_seq  = (state == IDLE) && i_start;
    count_next = count + CW'(push) - CW'(pop);
  end

  // The post-burst DRAIN/FILL decision looks at the count after this cycle's
  // push/pop so back-to-back bursts stay contiguous.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (i_start) state_next = FILL;
      FILL:  if (count >= BPS_C) state_next = DRAIN;
      DRAIN: begin
        if (last_pop) begin
          if (step == LAST_STEP_C)       state_next = DONE;
          else if (count_next >= BPS_C)  state_next = DRAIN;
          else                           state_next = FILL;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      acc_cnt       <= '0;
      beat_cnt      <= '0;
      step          <= '0;
      o_init_tdata  <= '0;
      o_init_tvalid <= 1'b0;
      o_step        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_tlast   <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      o_busy        <= (state_next != IDLE);
      o_done        <= (state_next == DONE);
      o_init_tvalid <= pop;

      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
        if (s_axis_tlast != (acc_cnt == LAST_IDX_C))
          o_err_tlast <= 1'b1;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        o_init_tdata <= mem[rd_ptr];
        o_step       <= step;
        beat_cnt     <= last_pop ? '0 : beat_cnt + 1'b1;
      end

      if (last_pop && step != LAST_STEP_C)
        step <= step + 1'b1;

      if (start_seq) begin
        step        <= '0;
        beat_cnt    <= '0;
        acc_cnt     <= '0;
        o_err_tlast <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_md_init_stream_feeder.sv
// Bench for md_init_stream_feeder: table of sequence scenarios plus random runs,
// checked by a queue-based stream model and directed reset sequences.
module tb_md_init_stream_feeder;

  localparam int DW    = 16;
  localparam int BPS   = 4;
  localparam int NS    = 2;
  localparam int DEPTH = 8;
  localparam int SW    = 1;
  localparam int TOTAL = NS * BPS;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] o_init_tdata;
  logic          o_init_tvalid;
  logic [SW-1:0] o_step;
  logic          o_busy;
  logic          o_done;
  logic          o_err_tlast;

  always #5 clk = ~clk;

  md_init_stream_feeder #(
    .DATA_WIDTH(DW), .BEATS_PER_STEP(BPS), .NUM_STEPS(NS),
    .FIFO_DEPTH(DEPTH), .STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .o_init_tdata(o_init_tdata), .o_init_tvalid(o_init_tvalid),
    .o_step(o_step), .o_busy(o_busy), .o_done(o_done), .o_err_tlast(o_err_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stream model: accepted beats in order, replayed one burst at a time.
  logic [DW-1:0] acc_q[$];
  int  out_n = 0, done_n = 0, cyc = 0, start_cyc = 0, first_out_cyc = -1;
  bit  model_err = 0, prev_valid = 0, start_ok = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_q.delete();
      out_n = 0; done_n = 0; model_err = 0; prev_valid = 0; first_out_cyc = -1;
    end else begin
      check("err_tlast", o_err_tlast, model_err);
      if (o_init_tvalid) begin
        if (!prev_valid) begin
          check("burst_align", out_n % BPS, 0);
          check("burst_prebuffered", (acc_q.size() - out_n) >= BPS, 1);
          if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (out_n < acc_q.size()) check("out_data", o_init_tdata, acc_q[out_n]);
        else                      check("out_excess", out_n, acc_q.size());
        check("out_step", o_step, out_n / BPS);
        out_n++;
      end else if (prev_valid) begin
        check("burst_len", out_n % BPS, 0);
      end
      prev_valid = o_init_tvalid;
      if (o_done) done_n++;
      if (s_axis_tvalid && s_axis_tready) begin
        check("accept_limit", acc_q.size() < TOTAL, 1);
        if (s_axis_tlast != (acc_q.size() == TOTAL - 1)) model_err = 1;
        acc_q.push_back(s_axis_tdata);
      end
      if (i_start && start_ok) begin
        acc_q.delete();
        out_n = 0; done_n = 0; model_err = 0; start_cyc = cyc; first_out_cyc = -1;
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_tdata"},  o_init_tdata, 0);
    check({tag, "_tvalid"}, o_init_tvalid, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_step"},   o_step, 0);
    check({tag, "_busy"},   o_busy, 0);
    check({tag, "_done"},   o_done, 0);
    check({tag, "_err"},    o_err_tlast, 0);
  endtask

  task automatic pulse_start();
    start_ok = 1; i_start = 1;
    @(posedge clk); #1;
    i_start = 0; start_ok = 0;
  endtask

  // One init sequence: gap = cycles between beat offers, base 0 = random data.
  task automatic run_seq(input int gap, input int tlast_idx, input int avail, input int base,
                         input int exp_lat, input bit busy_start, input bit exp_err);
    logic [DW-1:0] dat [12];
    int idx = 0, wait_cnt = 0, budget = 0;
    bit acc, seen_done = 0;
    for (int i = 0; i < 12; i++) dat[i] = (base != 0) ? DW'(base + i) : DW'($urandom);
    s_axis_tvalid = 0;
    pulse_start();
    while (budget < 300 && !seen_done) begin
      if (!s_axis_tvalid && idx < avail && wait_cnt == 0) begin
        s_axis_tvalid = 1;
        s_axis_tdata  = dat[idx];
        s_axis_tlast  = (idx == tlast_idx);
      end
      i_start = busy_start && (budget == 10);
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      if (o_done) seen_done = 1;
      @(posedge clk); #1;
      if (acc) begin
        idx++; s_axis_tvalid = 0; wait_cnt = gap - 1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      budget++;
    end
    i_start = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
    check("done_seen", seen_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("end_busy", o_busy, 0);
    check("end_tvalid", o_init_tvalid, 0);
    check("end_out_beats", out_n, TOTAL);
    check("end_acc_beats", acc_q.size(), TOTAL);
    check("end_done_pulses", done_n, 1);
    check("end_err_tlast", o_err_tlast, exp_err);
    if (exp_lat != 0) check("first_beat_latency", first_out_cyc - start_cyc, exp_lat);
  endtask

  typedef struct {
    int gap; int tlast_idx; int avail; int base; int exp_lat; bit busy_start; bit exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1,  7,  8,   1, 7, 0, 0};
    vecs[1] = '{3,  7,  8,   1, 0, 0, 0};
    vecs[2] = '{1,  7, 12,   1, 7, 0, 0};
    vecs[3] = '{1,  2,  8,   1, 7, 0, 1};
    vecs[4] = '{2, -1,  8, 100, 0, 1, 1};
    vecs[5] = '{1,  7,  8,   0, 7, 1, 0};

    rst = 1; i_start = 0; s_axis_tvalid = 1; s_axis_tdata = '1; s_axis_tlast = 1;
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("rst");
    end
    rst = 0;
    @(posedge clk); #1;
    check_quiet("post_rst");
    s_axis_tvalid = 0; s_axis_tlast = 0;

    for (int v = 0; v < 6; v++)
      run_seq(vecs[v].gap, vecs[v].tlast_idx, vecs[v].avail, vecs[v].base,
              vecs[v].exp_lat, vecs[v].busy_start, vecs[v].exp_err);

    for (int r = 0; r < 4; r++) begin
      int g, tl, av;
      g  = $urandom_range(1, 4);
      tl = ($urandom_range(0, 1) != 0) ? 7 : $urandom_range(0, 7);
      av = $urandom_range(8, 12);
      run_seq(g, tl, av, 0, (g == 1) ? 7 : 0, 0, tl != 7);
    end

    // Reset two beats into the second burst, then a fresh sequence 11..18.
    begin
      int idx = 0;
      bit acc;
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        if (out_n >= 5) break;
        s_axis_tvalid = (idx < TOTAL);
        s_axis_tdata  = DW'(idx + 1);
        s_axis_tlast  = (idx == TOTAL - 1);
        @(negedge clk);
        acc = s_axis_tvalid && s_axis_tready;
        @(posedge clk); #1;
        if (acc) idx++;
      end
      check("mid_rst_reached", out_n >= 5, 1);
      s_axis_tvalid = 0; s_axis_tlast = 0;
      rst = 1;
      @(posedge clk); #1;
      check_quiet("mid_rst");
      rst = 0;
      @(posedge clk); #1;
      check_quiet("mid_rst_idle");
      run_seq(1, 7, 8, 11, 7, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
